effect_key_ctrl: RTL and testbench

Downstream consumer of the debounced key stage. Takes three clean, clock-synchronous key levels (next/up/down) and converts them into audio-effect selection and a per-effect intensity level for the effect datapath. Handles edge detection, hold-to-auto-repeat, per-effect level storage with saturation, and a one-cycle change strobe that tells the effect datapath to reload coefficients.

---
 rtl/effect_key_ctrl.sv | 166 ++++++++++++++++
 tb/tb_effect_key_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/effect_key_ctrl.sv
// Effect selection and per-effect level control driven by three debounced keys.
// Press edges step the selection/level; holding up/down auto-repeats after a delay.
module effect_key_ctrl #(
    parameter int NUM_EFFECTS   = 4,
    parameter int LEVEL_W       = 4,
    parameter int LEVEL_DEFAULT = 8,
    parameter int HOLD_CYCLES   = 12500000,
    parameter int REPEAT_CYCLES = 2500000,
    localparam int SEL_W = (NUM_EFFECTS > 1) ? $clog2(NUM_EFFECTS) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               key_next,
    input  logic               key_up,
    input  logic               key_down,
    output logic [SEL_W-1:0]   effect_sel,
    output logic [LEVEL_W-1:0] level,
    output logic               changed,
    output logic               repeating
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(NUM_EFFECTS - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX   = '1;
    localparam logic [LEVEL_W-1:0] LVL_DEF   = LEVEL_W'(LEVEL_DEFAULT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               dir_up, dir_up_n;
    logic               next_q, up_q, down_q;
    logic [LEVEL_W-1:0] slots [NUM_EFFECTS];

    logic               next_edge, up_edge, down_edge;
    logic               held, step, slot_wr;
    logic [LEVEL_W-1:0] cur_slot, stepped;
    logic [SEL_W-1:0]   sel_n;
    logic [LEVEL_W-1:0] level_n;

    // Hold/auto-repeat decision: which state comes next and whether this cycle steps.
    always_comb begin
        next_edge = key_next & ~next_q;
        up_edge   = key_up & ~up_q;
        down_edge = key_down & ~down_q;
        held      = dir_up ? key_up : key_down;
        state_n   = state;
        cnt_n     = cnt;
        dir_up_n  = dir_up;
        step      = 1'b0;
        if (next_edge || effect_sel == '0 || (key_up && key_down)) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (up_edge || down_edge) begin
                        step     = 1'b1;
                        dir_up_n = up_edge;
                        state_n  = PRESS;
                        cnt_n    = '0;
                    end
                end
                PRESS: begin
                    if (!held) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == HOLD_TERM) begin
                        step    = 1'b1;
                        state_n = REPEAT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!held) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == REP_TERM) begin
                        step  = 1'b1;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Saturating level step on the current slot, then the values the outputs will show.
    always_comb begin
        cur_slot = slots[effect_sel];
        stepped  = cur_slot;
        slot_wr  = 1'b0;
        if (step) begin
            if (dir_up_n) begin
                if (cur_slot != LVL_MAX) begin
                    stepped = cur_slot + 1'b1;
                    slot_wr = 1'b1;
                end
            end else if (cur_slot != '0) begin
                stepped = cur_slot - 1'b1;
                slot_wr = 1'b1;
            end
        end

        sel_n = effect_sel;
        if (next_edge) begin
            sel_n = (effect_sel == SEL_LAST) ? '0 : effect_sel + 1'b1;
        end

        if (sel_n == '0) begin
            level_n = '0;
        end else if (slot_wr) begin
            level_n = stepped;
        end else begin
            level_n = slots[sel_n];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dir_up     <= 1'b0;
            next_q     <= 1'b1;
            up_q       <= 1'b1;
            down_q     <= 1'b1;
            effect_sel <= '0;
            level      <= '0;
            changed    <= 1'b0;
            repeating  <= 1'b0;
            for (int i = 0; i < NUM_EFFECTS; i++) begin
                slots[i] <= LVL_DEF;
            end
        end else begin
            next_q     <= key_next;
            up_q       <= key_up;
            down_q     <= key_down;
            state      <= state_n;
            cnt        <= cnt_n;
            dir_up     <= dir_up_n;
            effect_sel <= sel_n;
            level      <= level_n;
            changed    <= (sel_n != effect_sel) || (level_n != level);
            repeating  <= (state_n == REPEAT);
            if (slot_wr) begin
                slots[effect_sel] <= stepped;
            end
        end
    end

endmodule

// File: tb/tb_effect_key_ctrl.sv
// Bench for effect_key_ctrl: a hold-time reference model feeds an expected queue,
// directed checks cover the selection, hold/repeat, saturation and reset cases.
module tb_effect_key_ctrl;

  localparam int NE   = 4;
  localparam int LW   = 4;
  localparam int LD   = 8;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_next = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic [1:0] effect_sel;
  logic [3:0] level;
  logic       changed;
  logic       repeating;

  always #5 clock = ~clock;

  effect_key_ctrl #(
    .NUM_EFFECTS  (NE),
    .LEVEL_W      (LW),
    .LEVEL_DEFAULT(LD),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_next  (key_next),
    .key_up    (key_up),
    .key_down  (key_down),
    .effect_sel(effect_sel),
    .level     (level),
    .changed   (changed),
    .repeating (repeating)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // reference model state; m_held counts cycles the active key has been held
  logic       m_prev_nx, m_prev_up, m_prev_dn;
  logic [1:0] m_sel;
  logic [3:0] m_level;
  logic [3:0] m_slot [4];
  logic       m_dir;
  int         m_held;

  string phase = "init";
  int chg_seen, rep_seen, cyc_in_phase, first_rep;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_word();
    return 32'({effect_sel, level, changed, repeating});
  endfunction

  task automatic model_reset();
    m_prev_nx = 1'b1;
    m_prev_up = 1'b1;
    m_prev_dn = 1'b1;
    m_sel     = 2'd0;
    m_level   = 4'd0;
    m_dir     = 1'b0;
    m_held    = 0;
    for (int i = 0; i < 4; i++) m_slot[i] = 4'(LD);
  endtask

  task automatic model_cycle(input logic nx, input logic up, input logic dn);
    logic nx_e, up_e, dn_e, stp, chg, rep;
    logic [1:0] old_sel;
    logic [3:0] old_lvl;
    nx_e    = nx & ~m_prev_nx;
    up_e    = up & ~m_prev_up;
    dn_e    = dn & ~m_prev_dn;
    old_sel = m_sel;
    old_lvl = m_level;
    stp     = 1'b0;
    if (nx_e) begin
      m_sel  = (m_sel == 2'd3) ? 2'd0 : m_sel + 2'd1;
      m_held = 0;
    end else if (m_sel == 2'd0 || (up && dn)) begin
      m_held = 0;
    end else if (m_held == 0) begin
      if (up_e) begin
        m_dir = 1'b1; m_held = 1; stp = 1'b1;
      end else if (dn_e) begin
        m_dir = 1'b0; m_held = 1; stp = 1'b1;
      end
    end else if (m_dir ? up : dn) begin
      m_held++;
      if (m_held >= HOLD + 1 && ((m_held - HOLD - 1) % REP) == 0) stp = 1'b1;
    end else begin
      m_held = 0;
    end
    if (stp) begin
      if (m_dir && m_slot[m_sel] != 4'd15) m_slot[m_sel] = m_slot[m_sel] + 4'd1;
      else if (!m_dir && m_slot[m_sel] != 4'd0) m_slot[m_sel] = m_slot[m_sel] - 4'd1;
    end
    m_level = (m_sel == 2'd0) ? 4'd0 : m_slot[m_sel];
    chg = (m_sel != old_sel) || (m_level != old_lvl);
    rep = (m_held >= HOLD + 1);
    exp_q.push_back({m_sel, m_level, chg, rep});
    m_prev_nx = nx;
    m_prev_up = up;
    m_prev_dn = dn;
  endtask

  task automatic begin_phase(input string name);
    phase        = name;
    chg_seen     = 0;
    rep_seen     = 0;
    cyc_in_phase = 0;
    first_rep    = 0;
  endtask

  task automatic cycle(input logic nx, input logic up, input logic dn);
    logic [7:0] e;
    key_next = nx;
    key_up   = up;
    key_down = dn;
    model_cycle(nx, up, dn);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("sb", dut_word(), 32'(e));
    end
    cyc_in_phase++;
    if (changed) chg_seen++;
    if (repeating) begin
      rep_seen++;
      if (first_rep == 0) first_rep = cyc_in_phase;
    end
  endtask

  task automatic pulse_next();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset(input logic up);
    key_next = 1'b0;
    key_up   = up;
    key_down = 1'b0;
    reset    = 1'b1;
    #2;
    check("rst_async", dut_word(), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] sel_tab [4];
    logic [3:0] lvl_tab [4];
    logic rn, ru, rd;
    sel_tab = '{2'd1, 2'd2, 2'd3, 2'd0};
    lvl_tab = '{4'd8, 4'd8, 4'd8, 4'd0};

    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_state", dut_word(), 32'd0);
    reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);

    begin_phase("next4");
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      check("sel", 32'(effect_sel), 32'(sel_tab[i]));
      check("lvl", 32'(level), 32'(lvl_tab[i]));
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
    end
    check("chg_pulses", 32'(chg_seen), 32'd4);

    pulse_next();
    begin_phase("hold_up");
    repeat (30) cycle(1'b0, 1'b1, 1'b0);
    check("lvl_sat", 32'(level), 32'd15);
    check("chg_pulses", 32'(chg_seen), 32'd7);
    check("first_rep", 32'(first_rep), 32'd9);
    check("rep_cycles", 32'(rep_seen), 32'd22);
    cycle(1'b0, 1'b0, 1'b0);
    check("rep_release", 32'(repeating), 32'd0);

    pulse_next();
    begin_phase("down_pulses");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
    end
    check("lvl_zero", 32'(level), 32'd0);
    check("chg_pulses", 32'(chg_seen), 32'd8);
    repeat (3) pulse_next();
    check("sel_back", 32'(effect_sel), 32'd1);
    check("slot1_kept", 32'(level), 32'd15);

    apply_reset(1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    pulse_next();
    begin_phase("next_beats_up");
    cycle(1'b1, 1'b1, 1'b0);
    check("sel", 32'(effect_sel), 32'd2);
    check("lvl", 32'(level), 32'd8);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("chg_pulses", 32'(chg_seen), 32'd1);

    begin_phase("reset_held");
    cycle(1'b0, 1'b1, 1'b0);
    check("lvl_pre", 32'(level), 32'd9);
    cycle(1'b0, 1'b1, 1'b0);
    apply_reset(1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("sel", 32'(effect_sel), 32'd1);
    check("lvl_default", 32'(level), 32'd8);
    begin_phase("reset_held_post");
    repeat (12) cycle(1'b0, 1'b1, 1'b0);
    check("lvl_no_step", 32'(level), 32'd8);
    check("chg_pulses", 32'(chg_seen), 32'd0);
    check("rep_cycles", 32'(rep_seen), 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("lvl_repress", 32'(level), 32'd9);
    cycle(1'b0, 1'b0, 1'b0);

    repeat (3) pulse_next();
    begin_phase("bypass_up");
    repeat (20) cycle(1'b0, 1'b1, 1'b0);
    check("sel", 32'(effect_sel), 32'd0);
    check("lvl", 32'(level), 32'd0);
    check("chg_pulses", 32'(chg_seen), 32'd0);
    check("rep_cycles", 32'(rep_seen), 32'd0);
    cycle(1'b0, 1'b0, 1'b0);

    pulse_next();
    begin_phase("both_keys");
    cycle(1'b0, 1'b1, 1'b0);
    repeat (12) cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check("lvl", 32'(level), 32'd10);
    check("chg_pulses", 32'(chg_seen), 32'd1);
    check("rep_cycles", 32'(rep_seen), 32'd0);

    begin_phase("random");
    rn = 1'b0; ru = 1'b0; rd = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) rn = ~rn;
      if ($urandom_range(0, 9) == 0) ru = ~ru;
      if ($urandom_range(0, 11) == 0) rd = ~rd;
      cycle(rn, ru, rd);
    end

    phase = "end";
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
